// File: rtl/timer_contagem_if.sv
// Timer-entry interface between the keypad/controller side and the countdown timer.
// master = keypad encoder / microwave controller, slave = timer_contagem.
interface timer_contagem_if;
    logic [3:0] D;
    logic       loadn;
    logic       enablen;
    logic       pgt_1Hz;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       done;
    logic [1:0] state;

    modport master (
        output D, loadn, enablen, pgt_1Hz,
        input  min_tens, min_ones, sec_tens, sec_ones, zero, done, state
    );

    modport slave (
        input  D, loadn, enablen, pgt_1Hz,
        output min_tens, min_ones, sec_tens, sec_ones, zero, done, state
    );
endinterface

// File: rtl/timer_contagem.sv
// MM:SS BCD countdown timer: digits are shifted in from the keypad while idle,
// then counted down on each 1 Hz tick to 00:00, where a one-cycle done pulse fires.
module timer_contagem #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5
) (
    input  logic             clk100,
    input  logic             clearn,
    timer_contagem_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // dig_q[3]=min_tens, [2]=min_ones, [1]=sec_tens, [0]=sec_ones
    logic [3:0][3:0] dig_q, dig_d, dec_val;
    state_t          state_q, state_d;
    logic            loadn_q, tick_q;
    logic            done_q, done_d;
    logic            key_ev, tick_ev, is_zero, dec_zero, digit_ok;

    assign key_ev   = loadn_q & ~bus.loadn;
    assign tick_ev  = ~tick_q & bus.pgt_1Hz;
    assign is_zero  = (dig_q == '0);
    assign digit_ok = (bus.D <= 4'd9);

    // Edge-detect history for the key strobe and the 1 Hz tick
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            loadn_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            loadn_q <= bus.loadn;
            tick_q  <= bus.pgt_1Hz;
        end
    end

    // One-step BCD decrement with borrow; seconds tens reload on borrow only,
    // so entered values like 0:99 just count down digit-wise
    always_comb begin
        dec_val = dig_q;
        if (dig_q[0] != 4'd0) begin
            dec_val[0] = dig_q[0] - 4'd1;
        end else begin
            dec_val[0] = 4'd9;
            if (dig_q[1] != 4'd0) begin
                dec_val[1] = dig_q[1] - 4'd1;
            end else begin
                dec_val[1] = SEC_TENS_MAX;
                if (dig_q[2] != 4'd0) begin
                    dec_val[2] = dig_q[2] - 4'd1;
                end else begin
                    dec_val[2] = 4'd9;
                    dec_val[3] = dig_q[3] - 4'd1;
                end
            end
        end
        dec_zero = (dec_val == '0);
    end

    // Next-state, next-digit and done-pulse logic
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_ev && digit_ok)
                    dig_d = {dig_q[2], dig_q[1], dig_q[0], bus.D};
                if (!bus.enablen && !is_zero)
                    state_d = RUN;
            end
            RUN: begin
                // A tick wins over a same-cycle pause: decrement first, then leave
                if (tick_ev && !is_zero) begin
                    dig_d = dec_val;
                    if (dec_zero) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (bus.enablen) begin
                        state_d = IDLE;
                    end
                end else if (bus.enablen) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (bus.enablen)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, digit and done registers
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            state_q <= IDLE;
            dig_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
        end
    end

    assign bus.min_tens = dig_q[3];
    assign bus.min_ones = dig_q[2];
    assign bus.sec_tens = dig_q[1];
    assign bus.sec_ones = dig_q[0];
    assign bus.zero     = is_zero;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule
